sort_pkt_arbiter: RTL and testbench
===================================

Name: sort_pkt_arbiter

Overview:
- Shares one packet sort engine between N_PORTS Avalon-ST requesters.
- Grants whole packets, round-robin, and steers each packet into the engine's sink.
- Records the owning port in a tag FIFO and routes the engine's sorted output packet back to that port.
- Sits between the requester ports and the sort engine's snk_*/src_* interfaces.

Parameters:
- N_PORTS, 4, number of requester ports (2..16).
- DWIDTH, 8, data width in bits.
- TAG_DEPTH, 4, packets allowed in flight inside the engine (power of 2).

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset, asynchronous, active-high.
- req_data_i  in  N_PORTS*DWIDTH  per-port sink data; port k occupies bits [k*DWIDTH +: DWIDTH].
- req_startofpacket_i  in  N_PORTS  per-port start of packet.
- req_endofpacket_i  in  N_PORTS  per-port end of packet.
- req_valid_i  in  N_PORTS  per-port valid.
- req_ready_o  out  N_PORTS  per-port ready.
- eng_data_o  out  DWIDTH  data to the engine sink.
- eng_startofpacket_o  out  1  start of packet to the engine sink.
- eng_endofpacket_o  out  1  end of packet to the engine sink.
- eng_valid_o  out  1  valid to the engine sink.
- eng_ready_i  in  1  engine sink ready.
- eng_data_i  in  DWIDTH  sorted data from the engine source.
- eng_startofpacket_i  in  1  start of packet from the engine source.
- eng_endofpacket_i  in  1  end of packet from the engine source.
- eng_valid_i  in  1  valid from the engine source.
- eng_ready_o  out  1  ready to the engine source.
- res_data_o  out  DWIDTH  result data, broadcast to all ports.
- res_startofpacket_o  out  1  result start of packet, broadcast.
- res_endofpacket_o  out  1  result end of packet, broadcast.
- res_valid_o  out  N_PORTS  result valid, one-hot to the owning port.
- res_ready_i  in  N_PORTS  per-port result ready.
- proto_err_o  out  1  one-cycle pulse on a dropped beat.

Behaviour:
- Reset (arst_i high, asynchronous):
  - FSM goes to IDLE, RR pointer = 0, tag FIFO empty.
  - req_ready_o, eng_valid_o, eng_ready_o, res_valid_o and proto_err_o all 0.
  - Reset mid-packet abandons both sides; the engine is reset alongside.
- A handshake (beat) occurs when valid and ready are both high on the same clk_i edge.
- FSM IDLE:
  - Candidate = port with req_valid_i & req_startofpacket_i.
  - When the tag FIFO is not full, pick the first candidate at or after the RR pointer (wrapping), register grant = k, push k to the tag FIFO, go to BUSY.
  - Arbitration costs one cycle; the first beat cannot be accepted in the IDLE cycle.
  - If the tag FIFO is full, no grant is made.
- FSM BUSY, combinational forward from the granted port:
  - eng_* = req_*[grant].
  - req_ready_o[grant] = eng_ready_i; all other req_ready_o = 0.
  - On an endofpacket beat, RR pointer = grant+1 mod N_PORTS and the FSM returns to IDLE.
  - A single-beat packet (sop and eop together) behaves the same way.
- Ungranted ports:
  - Beats with startofpacket are held (ready low) until granted.
  - In IDLE, a port with valid and no startofpacket, and no candidate at all, is given ready=1 for one cycle. The beat is dropped and proto_err_o pulses.
  - That port is the lowest such index at or after the pointer.
- Return path, tag FIFO not empty, head = h:
  - res_* = eng_*.
  - res_valid_o = eng_valid_i << h.
  - eng_ready_o = res_ready_i[h].
  - The tag is popped on an endofpacket beat from the engine.
  - When the tag FIFO is empty: eng_ready_o = 0, res_valid_o = 0.
- Tag FIFO:
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - A push is never issued when full; a pop is never issued when empty.
- Priority and ordering:
  - At most one packet is in transfer on the sink side.
  - Return order equals grant order.
  - The return path is independent of the FSM state and runs concurrently.

Test Plan:
- Port 2 only sends 10 random bytes, sop on beat 0, eop on beat 9 -> one IDLE cycle, then 10 beats on eng_*; sorted result returned with only res_valid_o[2] high.
- Ports 0,1,3 all request at once from reset -> grants in order 0,1,3; results on res_valid_o bits 0,1,3 in that order; RR pointer = 0 afterwards.
- Port 0 sends 3 consecutive packets while port 1 also requests -> order 0,1,0,1,0; no port granted twice in a row while another is waiting.
- TAG_DEPTH=4, engine source stalled (res_ready_i=0), 5 packets offered -> 4 granted, 5th held (req_ready_o=0) until the first result eop beat, then granted.
- Port 3 asserts valid without sop while idle, no other requests -> one-cycle req_ready_o[3], proto_err_o pulse, nothing on eng_valid_o.
- arst_i asserted mid-packet at beat 5 of 1023 -> all outputs 0 immediately; next packet on port 1 is granted normally after release.

Source files
------------

// File: rtl/sort_pkt_arbiter.sv
// sort_pkt_arbiter: round-robin whole-packet arbiter in front of a shared
// sort engine; a tag FIFO steers each sorted result back to its owner.
module sort_pkt_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int DWIDTH    = 8,
    parameter int TAG_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [N_PORTS*DWIDTH-1:0] req_data_i,
    input  logic [N_PORTS-1:0]        req_startofpacket_i,
    input  logic [N_PORTS-1:0]        req_endofpacket_i,
    input  logic [N_PORTS-1:0]        req_valid_i,
    output logic [N_PORTS-1:0]        req_ready_o,
    output logic [DWIDTH-1:0]         eng_data_o,
    output logic                      eng_startofpacket_o,
    output logic                      eng_endofpacket_o,
    output logic                      eng_valid_o,
    input  logic                      eng_ready_i,
    input  logic [DWIDTH-1:0]         eng_data_i,
    input  logic                      eng_startofpacket_i,
    input  logic                      eng_endofpacket_i,
    input  logic                      eng_valid_i,
    output logic                      eng_ready_o,
    output logic [DWIDTH-1:0]         res_data_o,
    output logic                      res_startofpacket_o,
    output logic                      res_endofpacket_o,
    output logic [N_PORTS-1:0]        res_valid_o,
    input  logic [N_PORTS-1:0]        res_ready_i,
    output logic                      proto_err_o
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant;
    logic [PW-1:0]      grant_nxt;
    logic [PW-1:0]      pick;
    logic [PW-1:0]      drop_port;
    logic               pick_ok;
    logic               drop_ok;
    logic               cand_any;
    logic               drop_fire;
    logic               sink_last;
    logic [N_PORTS-1:0] cand;
    logic [N_PORTS-1:0] stray;
    int                 j;

    logic [PW-1:0]      tag_mem [TAG_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [PW-1:0]      head;
    logic               tag_full;
    logic               tag_empty;
    logic               push;
    logic               pop;

    assign tag_full  = (count == CW'(TAG_DEPTH));
    assign tag_empty = (count == '0);
    assign head      = tag_mem[rd_ptr];
    assign grant_nxt = (grant == PW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
    assign push      = (state == IDLE) && pick_ok && !tag_full;

    // Scan from the RR pointer for the first sop candidate and first stray beat.
    always_comb begin
        cand      = req_valid_i & req_startofpacket_i;
        stray     = req_valid_i & ~req_startofpacket_i;
        cand_any  = |cand;
        pick      = rr_ptr;
        pick_ok   = 1'b0;
        drop_port = rr_ptr;
        drop_ok   = 1'b0;
        j         = 0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (cand[j]) begin
                pick    = PW'(j);
                pick_ok = 1'b1;
            end
            if (stray[j]) begin
                drop_port = PW'(j);
                drop_ok   = 1'b1;
            end
        end
    end

    // Sink side: forward the granted port, or swallow one stray beat when idle.
    always_comb begin
        req_ready_o         = '0;
        eng_data_o          = req_data_i[grant*DWIDTH +: DWIDTH];
        eng_startofpacket_o = req_startofpacket_i[grant];
        eng_endofpacket_o   = req_endofpacket_i[grant];
        eng_valid_o         = 1'b0;
        drop_fire           = 1'b0;
        sink_last           = 1'b0;
        if (state == BUSY) begin
            eng_valid_o        = req_valid_i[grant];
            req_ready_o[grant] = eng_ready_i;
            sink_last          = req_valid_i[grant] && eng_ready_i &&
                                 req_endofpacket_i[grant];
        end else if (!cand_any && drop_ok && !arst_i) begin
            req_ready_o[drop_port] = 1'b1;
            drop_fire              = 1'b1;
        end
    end

    // Return side: steer engine output to the port at the tag FIFO head.
    always_comb begin
        res_data_o          = eng_data_i;
        res_startofpacket_o = eng_startofpacket_i;
        res_endofpacket_o   = eng_endofpacket_i;
        res_valid_o         = '0;
        eng_ready_o         = 1'b0;
        pop                 = 1'b0;
        if (!tag_empty) begin
            res_valid_o = {{(N_PORTS-1){1'b0}}, eng_valid_i} << head;
            eng_ready_o = res_ready_i[head];
            pop         = eng_valid_i && res_ready_i[head] && eng_endofpacket_i;
        end
    end

    // Arbitration FSM: grant a whole packet, advance the pointer on its eop.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            proto_err_o <= 1'b0;
        end else begin
            proto_err_o <= drop_fire;
            unique case (state)
                IDLE: begin
                    if (pick_ok && !tag_full) begin
                        grant <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (sink_last) begin
                        rr_ptr <= grant_nxt;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    // Tag FIFO pointers and occupancy; simultaneous push and pop keep count.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Tag storage; contents are only read while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_mem[wr_ptr] <= pick;
        end
    end

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// tb_sort_pkt_arbiter: directed packets from the ports, a behavioural sort
// engine, and a scoreboard checking every returned beat and its owner.
module tb_sort_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TD = 4;

    typedef logic [7:0] bq_t[$];

    logic            clk = 1'b0;
    logic            arst_i = 1'b1;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N-1:0]    req_startofpacket_i = '0;
    logic [N-1:0]    req_endofpacket_i = '0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [DW-1:0]   eng_data_o;
    logic            eng_startofpacket_o;
    logic            eng_endofpacket_o;
    logic            eng_valid_o;
    logic            eng_ready_i = 1'b1;
    logic [DW-1:0]   eng_data_i = '0;
    logic            eng_startofpacket_i = 1'b0;
    logic            eng_endofpacket_i = 1'b0;
    logic            eng_valid_i = 1'b0;
    logic            eng_ready_o;
    logic [DW-1:0]   res_data_o;
    logic            res_startofpacket_o;
    logic            res_endofpacket_o;
    logic [N-1:0]    res_valid_o;
    logic [N-1:0]    res_ready_i = '1;
    logic            proto_err_o;

    int checks = 0;
    int errors = 0;

    int          exp_port[$];
    int          exp_len[$];
    logic [7:0]  exp_data[$];

    bq_t         snk_buf;
    bq_t         snk_sorted;
    int          pkt_len[$];
    logic [7:0]  pkt_data[$];
    int          sink_eops = 0;
    int          perr_cnt = 0;
    int          engv_cnt = 0;
    bit          bp_en = 1'b0;

    sort_pkt_arbiter #(
        .N_PORTS(N),
        .DWIDTH(DW),
        .TAG_DEPTH(TD)
    ) dut (
        .clk_i(clk),
        .arst_i(arst_i),
        .req_data_i(req_data_i),
        .req_startofpacket_i(req_startofpacket_i),
        .req_endofpacket_i(req_endofpacket_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .eng_data_o(eng_data_o),
        .eng_startofpacket_o(eng_startofpacket_o),
        .eng_endofpacket_o(eng_endofpacket_o),
        .eng_valid_o(eng_valid_o),
        .eng_ready_i(eng_ready_i),
        .eng_data_i(eng_data_i),
        .eng_startofpacket_i(eng_startofpacket_i),
        .eng_endofpacket_i(eng_endofpacket_i),
        .eng_valid_i(eng_valid_i),
        .eng_ready_o(eng_ready_o),
        .res_data_o(res_data_o),
        .res_startofpacket_o(res_startofpacket_o),
        .res_endofpacket_o(res_endofpacket_o),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .proto_err_o(proto_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gen(input int seed, input int i);
        return 8'(seed * 73 + i * 151 + i * i * 7);
    endfunction

    function automatic bq_t sort_q(input bq_t q);
        bq_t r;
        logic [7:0] t;
        int k;
        r = q;
        for (int i = 1; i < r.size(); i++) begin
            t = r[i];
            k = i - 1;
            while (k >= 0 && r[k] > t) begin
                r[k+1] = r[k];
                k--;
            end
            r[k+1] = t;
        end
        return r;
    endfunction

    function automatic void push_exp(input int port, input int len, input int seed);
        bq_t q;
        q = {};
        for (int i = 0; i < len; i++) q.push_back(gen(seed, i));
        q = sort_q(q);
        foreach (q[i]) exp_data.push_back(q[i]);
        exp_port.push_back(port);
        exp_len.push_back(len);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one packet on a port; stop early (beat left presented) at beat 'stop'.
    task automatic send_pkt(input int port, input int len, input int seed,
                            input int stop, output int wait0);
        int cyc;
        wait0 = 0;
        for (int b = 0; b < len; b++) begin
            if (b == stop) return;
            req_data_i[port*DW +: DW]  = gen(seed, b);
            req_startofpacket_i[port] = (b == 0);
            req_endofpacket_i[port]   = (b == len - 1);
            req_valid_i[port]         = 1'b1;
            cyc = 0;
            forever begin
                @(negedge clk);
                if (req_ready_o[port]) break;
                cyc++;
                if (cyc > 3000) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_timeout port=%0d beat=%0d waited=%0d", port, b, cyc);
                    req_valid_i[port] = 1'b0;
                    return;
                end
            end
            if (b == 0) wait0 = cyc;
            @(posedge clk);
            #1;
        end
        req_valid_i[port]         = 1'b0;
        req_startofpacket_i[port] = 1'b0;
        req_endofpacket_i[port]   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_port.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_pending"}, exp_port.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        arst_i              = 1'b1;
        req_valid_i         = '0;
        req_startofpacket_i = '0;
        req_endofpacket_i   = '0;
        repeat (2) @(posedge clk);
        #3;
        arst_i = 1'b0;
        exp_port.delete();
        exp_len.delete();
        exp_data.delete();
    endtask

    // Engine sink model: collect a packet, sort it, queue it for the source.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_i) begin
                snk_buf.delete();
            end else begin
                if (eng_valid_o) engv_cnt++;
                if (proto_err_o) perr_cnt++;
                if (eng_valid_o && eng_ready_i) begin
                    snk_buf.push_back(eng_data_o);
                    if (eng_endofpacket_o) begin
                        snk_sorted = sort_q(snk_buf);
                        foreach (snk_sorted[i]) pkt_data.push_back(snk_sorted[i]);
                        pkt_len.push_back(snk_sorted.size());
                        snk_buf.delete();
                        sink_eops++;
                    end
                end
            end
        end
    end

    // Engine source model: replay sorted packets honouring eng_ready_o.
    initial begin
        int  idx;
        bit  fire;
        idx = 0;
        forever begin
            @(negedge clk);
            fire = eng_valid_i && eng_ready_o;
            @(posedge clk);
            #1;
            if (arst_i) begin
                eng_valid_i = 1'b0;
                pkt_len.delete();
                pkt_data.delete();
                idx = 0;
            end else begin
                if (fire) begin
                    idx++;
                    if (idx == pkt_len[0]) begin
                        repeat (pkt_len[0]) void'(pkt_data.pop_front());
                        void'(pkt_len.pop_front());
                        idx = 0;
                    end
                end
                if (pkt_len.size() > 0) begin
                    eng_valid_i         = 1'b1;
                    eng_data_i          = pkt_data[idx];
                    eng_startofpacket_i = (idx == 0);
                    eng_endofpacket_i   = (idx == pkt_len[0] - 1);
                end else begin
                    eng_valid_i         = 1'b0;
                    eng_startofpacket_i = 1'b0;
                    eng_endofpacket_i   = 1'b0;
                end
            end
        end
    end

    // Optional sink backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            eng_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Result monitor: every accepted result beat against the scoreboard.
    initial begin
        int beat;
        int p;
        int ep;
        int el;
        logic [7:0] ed;
        beat = 0;
        forever begin
            @(negedge clk);
            if (arst_i) begin
                beat = 0;
                continue;
            end
            if ((res_valid_o & res_ready_i) != '0) begin
                p = -1;
                for (int k = 0; k < N; k++) if (res_valid_o[k]) p = k;
                checks++;
                if (exp_port.size() == 0) begin
                    errors++;
                    $display("FAIL res_unexpected valid=%b data=%02h required=none",
                             res_valid_o, res_data_o);
                end else begin
                    ep = exp_port[0];
                    el = exp_len[0];
                    ed = exp_data[beat];
                    if (!$onehot(res_valid_o) || p != ep || res_data_o != ed ||
                        res_startofpacket_o != (beat == 0) ||
                        res_endofpacket_o != (beat == el - 1)) begin
                        errors++;
                        $display("FAIL res_beat%0d actual valid=%b data=%02h sop=%b eop=%b required port=%0d data=%02h sop=%b eop=%b",
                                 beat, res_valid_o, res_data_o, res_startofpacket_o,
                                 res_endofpacket_o, ep, ed, beat == 0, beat == el - 1);
                    end
                    beat++;
                    if (beat == el) begin
                        repeat (el) void'(exp_data.pop_front());
                        void'(exp_port.pop_front());
                        void'(exp_len.pop_front());
                        beat = 0;
                    end
                end
            end
        end
    end

    initial begin
        int w0, w1, w2, w3;
        int base, pbase, vbase, rcnt, cyc;

        #1;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_eng_valid", eng_valid_o, 0);
        chk("rst_eng_ready", eng_ready_o, 0);
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_proto_err", proto_err_o, 0);
        repeat (2) @(posedge clk);
        #3;
        arst_i = 1'b0;
        @(posedge clk);
        #1;

        // single packet on port 2
        base = sink_eops;
        push_exp(2, 10, 11);
        send_pkt(2, 10, 11, -1, w0);
        chk("t1_first_wait", w0, 1);
        wait_drain("t1");
        chk("t1_sink_pkts", sink_eops - base, 1);
        chk("t1_proto_err", perr_cnt, 0);

        // three simultaneous requesters, then pointer back at 0
        do_reset();
        push_exp(0, 4, 20);
        push_exp(1, 3, 21);
        push_exp(3, 5, 23);
        fork
            send_pkt(0, 4, 20, -1, w0);
            send_pkt(1, 3, 21, -1, w1);
            send_pkt(3, 5, 23, -1, w3);
        join
        wait_drain("t2a");
        push_exp(0, 2, 24);
        push_exp(3, 2, 25);
        fork
            send_pkt(0, 2, 24, -1, w0);
            send_pkt(3, 2, 25, -1, w3);
        join
        wait_drain("t2b");

        // fairness under sink backpressure, includes a single-beat packet
        do_reset();
        bp_en = 1'b1;
        push_exp(0, 3, 30);
        push_exp(1, 6, 40);
        push_exp(0, 5, 31);
        push_exp(1, 2, 41);
        push_exp(0, 1, 32);
        fork
            begin
                send_pkt(0, 3, 30, -1, w0);
                send_pkt(0, 5, 31, -1, w0);
                send_pkt(0, 1, 32, -1, w0);
            end
            begin
                send_pkt(1, 6, 40, -1, w1);
                send_pkt(1, 2, 41, -1, w1);
            end
        join
        wait_drain("t3");
        bp_en = 1'b0;

        // tag FIFO full while results are stalled
        do_reset();
        res_ready_i = '0;
        base = sink_eops;
        push_exp(0, 4, 50);
        push_exp(1, 4, 51);
        push_exp(2, 4, 52);
        push_exp(3, 4, 53);
        push_exp(0, 4, 54);
        fork
            begin
                send_pkt(0, 4, 50, -1, w0);
                send_pkt(0, 4, 54, -1, w0);
            end
            send_pkt(1, 4, 51, -1, w1);
            send_pkt(2, 4, 52, -1, w2);
            send_pkt(3, 4, 53, -1, w3);
            begin
                repeat (150) @(negedge clk);
                chk("t4_granted", sink_eops - base, 4);
                chk("t4_held_ready", req_ready_o, 0);
                chk("t4_res_valid", res_valid_o, 4'b0001);
                chk("t4_eng_ready", eng_ready_o, 0);
                @(posedge clk);
                #1;
                res_ready_i = '1;
            end
        join
        wait_drain("t4");
        chk("t4_total", sink_eops - base, 5);

        // stray beat without sop on port 3 while idle
        do_reset();
        pbase = perr_cnt;
        vbase = engv_cnt;
        rcnt  = 0;
        req_data_i[3*DW +: DW] = 8'h55;
        req_valid_i[3] = 1'b1;
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (req_ready_o[3]) begin
                rcnt++;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid_i[3] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready_o[3]) rcnt++;
        end
        chk("t5_ready_cycles", rcnt, 1);
        chk("t5_ready_wait", cyc, 1);
        chk("t5_proto_err", perr_cnt - pbase, 1);
        chk("t5_eng_valid", engv_cnt - vbase, 0);

        // reset in the middle of a long packet
        do_reset();
        base = sink_eops;
        send_pkt(1, 1023, 77, 5, w1);
        chk("t6_pre_eng_valid", eng_valid_o, 1);
        #2;
        arst_i = 1'b1;
        #1;
        chk("t6_req_ready", req_ready_o, 0);
        chk("t6_eng_valid", eng_valid_o, 0);
        chk("t6_eng_ready", eng_ready_o, 0);
        chk("t6_res_valid", res_valid_o, 0);
        chk("t6_proto_err", proto_err_o, 0);
        req_valid_i = '0;
        req_startofpacket_i = '0;
        req_endofpacket_i = '0;
        repeat (2) @(posedge clk);
        #3;
        arst_i = 1'b0;
        @(posedge clk);
        #1;
        push_exp(1, 3, 78);
        send_pkt(1, 3, 78, -1, w1);
        chk("t6_first_wait", w1, 1);
        wait_drain("t6");
        chk("t6_sink_pkts", sink_eops - base, 1);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
